decode_sync_ctrl: RTL and testbench

//  Word-alignment and link-sync controller wrapped around the 8b/10b decode block. Watches raw 10b words
//  for commas and the decoder's code/disparity error flags. Drives a bitslip pulse to the deserializer
//  and a sync reset to the decoder until alignment is found. Declares/loses sync with hysteresis, then

---
 rtl/decode_sync_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_decode_sync_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sync_ctrl.sv
// Word-alignment and link-sync controller for an 8b/10b decoder: hunts for commas, slips the
// deserializer word boundary, declares/loses sync with hysteresis and forwards decoded words.
`timescale 1ns/1ps
module decode_sync_ctrl #(
    parameter int unsigned COMMA_CNT  = 3,
    parameter int unsigned SEARCH_LEN = 64,
    parameter int unsigned SLIP_WAIT  = 16,
    parameter int unsigned ERR_LOSS   = 4,
    parameter int unsigned GOOD_RUN   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data_in,
    input  logic       rx_valid,
    input  logic [8:0] dec_data,
    input  logic       dec_code_err,
    input  logic       dec_disp_err,
    output logic       dec_rst_n,
    output logic       bitslip,
    output logic       sync,
    output logic [8:0] data_out,
    output logic       data_valid,
    output logic       link_err,
    output logic [7:0] slip_cnt
);

    localparam int unsigned SRCH_W = $clog2(SEARCH_LEN + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int unsigned CCNT_W = $clog2(COMMA_CNT + 1);
    localparam int unsigned GCNT_W = $clog2(GOOD_RUN + 1);
    localparam int unsigned ECNT_W = 4;

    localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [CCNT_W-1:0] CCNT_LAST = CCNT_W'(COMMA_CNT - 1);
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GOOD_RUN - 1);
    localparam logic [ECNT_W-1:0] ECNT_LAST = ECNT_W'(ERR_LOSS - 1);

    typedef enum logic [2:0] {
        ST_LOSS,
        ST_SLIP,
        ST_WAIT,
        ST_COMMA_DET,
        ST_SYNC
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_comma_d, r_valid_d;
    logic [SRCH_W-1:0]  r_srch, w_srch_nxt;
    logic [WAIT_W-1:0]  r_wcnt, w_wcnt_nxt;
    logic [CCNT_W-1:0]  r_ccnt, w_ccnt_nxt;
    logic [ECNT_W-1:0]  r_ecnt, w_ecnt_nxt;
    logic [GCNT_W-1:0]  r_gcnt, w_gcnt_nxt;
    logic [7:0]         r_slip_cnt, w_slip_nxt;
    logic               r_bitslip, r_dec_rst_n, r_sync, r_data_valid, r_link_err;
    logic [8:0]         r_data_out;
    logic               w_comma, w_err, w_cerr;
    logic               w_unused_hi;

    // Only bits a..f,i carry the comma signature; g,h,j are not needed here.
    assign w_comma     = (rx_data_in[6:0] == 7'b1111100) || (rx_data_in[6:0] == 7'b0000011);
    assign w_unused_hi = ^rx_data_in[9:7];
    assign w_err       = r_valid_d && (dec_code_err || dec_disp_err);
    assign w_cerr      = r_valid_d && dec_code_err;

    always_comb begin
        w_state_nxt = r_state;
        w_srch_nxt  = r_srch;
        w_wcnt_nxt  = r_wcnt;
        w_ccnt_nxt  = r_ccnt;
        w_ecnt_nxt  = r_ecnt;
        w_gcnt_nxt  = r_gcnt;
        w_slip_nxt  = r_slip_cnt;
        unique case (r_state)
            ST_LOSS: begin
                if (r_valid_d) begin
                    if (r_comma_d && !dec_code_err) begin
                        w_state_nxt = ST_COMMA_DET;
                        w_ccnt_nxt  = CCNT_W'(1);
                        w_srch_nxt  = '0;
                    end else if (r_srch == SRCH_LAST) begin
                        w_state_nxt = ST_SLIP;
                        w_srch_nxt  = '0;
                    end else begin
                        w_srch_nxt = r_srch + SRCH_W'(1);
                    end
                end
            end
            ST_SLIP: begin
                w_state_nxt = ST_WAIT;
                w_wcnt_nxt  = '0;
                if (r_slip_cnt != 8'hFF) w_slip_nxt = r_slip_cnt + 8'd1;
            end
            ST_WAIT: begin
                if (r_wcnt == WAIT_LAST) begin
                    w_state_nxt = ST_LOSS;
                    w_srch_nxt  = '0;
                end else begin
                    w_wcnt_nxt = r_wcnt + WAIT_W'(1);
                end
            end
            ST_COMMA_DET: begin
                // Disparity errors are tolerated: running disparity is unknown after a decoder reset.
                if (w_cerr) begin
                    w_state_nxt = ST_LOSS;
                    w_srch_nxt  = '0;
                end else if (r_valid_d && r_comma_d) begin
                    w_ccnt_nxt = r_ccnt + CCNT_W'(1);
                    if (r_ccnt == CCNT_LAST) begin
                        w_state_nxt = ST_SYNC;
                        w_ecnt_nxt  = '0;
                        w_gcnt_nxt  = '0;
                    end
                end
            end
            ST_SYNC: begin
                if (w_err) begin
                    w_ecnt_nxt = r_ecnt + ECNT_W'(1);
                    w_gcnt_nxt = '0;
                    if (r_ecnt == ECNT_LAST) begin
                        w_state_nxt = ST_LOSS;
                        w_slip_nxt  = '0;
                        w_srch_nxt  = '0;
                    end
                end else if (r_valid_d) begin
                    if (r_ecnt == '0) begin
                        if (r_gcnt != GCNT_LAST) w_gcnt_nxt = r_gcnt + GCNT_W'(1);
                    end else if (r_gcnt == GCNT_LAST) begin
                        w_ecnt_nxt = r_ecnt - ECNT_W'(1);
                        w_gcnt_nxt = '0;
                    end else begin
                        w_gcnt_nxt = r_gcnt + GCNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_LOSS;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_LOSS;
            r_comma_d    <= 1'b0;
            r_valid_d    <= 1'b0;
            r_srch       <= '0;
            r_wcnt       <= '0;
            r_ccnt       <= '0;
            r_ecnt       <= '0;
            r_gcnt       <= '0;
            r_slip_cnt   <= '0;
            r_bitslip    <= 1'b0;
            r_dec_rst_n  <= 1'b0;
            r_sync       <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_link_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_comma_d    <= w_comma;
            r_valid_d    <= rx_valid;
            r_srch       <= w_srch_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_ccnt       <= w_ccnt_nxt;
            r_ecnt       <= w_ecnt_nxt;
            r_gcnt       <= w_gcnt_nxt;
            r_slip_cnt   <= w_slip_nxt;
            // Status outputs are registered from the next state so they line up with r_state.
            r_bitslip    <= (w_state_nxt == ST_SLIP);
            r_dec_rst_n  <= (w_state_nxt != ST_SLIP);
            r_sync       <= (w_state_nxt == ST_SYNC);
            r_data_valid <= (r_state == ST_SYNC) && r_valid_d;
            r_link_err   <= (r_state == ST_SYNC) && w_err;
            if (r_state == ST_SYNC) r_data_out <= dec_data;
        end
    end

    assign dec_rst_n  = r_dec_rst_n;
    assign bitslip    = r_bitslip;
    assign sync       = r_sync;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign link_err   = r_link_err;
    assign slip_cnt   = r_slip_cnt;

endmodule

// File: tb/tb_decode_sync_ctrl.sv
// Self-checking bench for decode_sync_ctrl: behavioural link model, randomized word stream,
// directed alignment/error/reset scenarios and a toy deserializer that reacts to bitslip.
`timescale 1ns/1ps
module tb_decode_sync_ctrl;

    localparam int SEARCH_LEN = 64;
    localparam int SLIP_WAIT  = 16;
    localparam int COMMA_CNT  = 3;
    localparam int ERR_LOSS   = 4;
    localparam int GOOD_RUN   = 4;
    localparam logic [9:0] K285N = 10'h17C;
    localparam logic [9:0] K285P = 10'h283;
    localparam int HUNT = 0, SLIPPING = 1, SETTLE = 2, CONFIRM = 3, LOCKED = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] rx_data_in = '0;
    logic       rx_valid = 1'b0;
    logic [8:0] dec_data = '0;
    logic       dec_code_err = 1'b0;
    logic       dec_disp_err = 1'b0;
    logic       dec_rst_n, bitslip, sync, data_valid, link_err;
    logic [8:0] data_out;
    logic [7:0] slip_cnt;

    always #5 clk = ~clk;

    decode_sync_ctrl #(
        .COMMA_CNT (COMMA_CNT),
        .SEARCH_LEN(SEARCH_LEN),
        .SLIP_WAIT (SLIP_WAIT),
        .ERR_LOSS  (ERR_LOSS),
        .GOOD_RUN  (GOOD_RUN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data_in  (rx_data_in),
        .rx_valid    (rx_valid),
        .dec_data    (dec_data),
        .dec_code_err(dec_code_err),
        .dec_disp_err(dec_disp_err),
        .dec_rst_n   (dec_rst_n),
        .bitslip     (bitslip),
        .sync        (sync),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .link_err    (link_err),
        .slip_cnt    (slip_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_edge = 0;
    int misalign = 0;
    int slip_edges[$];
    int le_count;

    // Link model state
    int m_mode, m_srch, m_wait, m_commas, m_errs, m_good, m_slips;
    bit m_vd, m_cd;
    bit e_sync, e_bs, e_drn, e_dv, e_le;
    logic [8:0] e_dout;

    // Decoder emulation: outputs lag the raw word by one word slot
    logic [8:0] p_data = '0;
    bit p_code = 0, p_disp = 0;

    function automatic bit is_comma(input logic [9:0] w);
        logic [6:0] low;
        low = w[6:0];
        return (low == K285N[6:0]) || (low == K285P[6:0]);
    endfunction

    function automatic logic [9:0] noncomma();
        logic [9:0] w;
        do w = 10'($urandom_range(1023)); while (is_comma(w));
        return w;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, n_edge, $time);
    endtask

    task automatic model_reset();
        m_mode = HUNT; m_srch = 0; m_wait = 0; m_commas = 0; m_errs = 0; m_good = 0; m_slips = 0;
        m_vd = 0; m_cd = 0;
        e_sync = 0; e_bs = 0; e_drn = 0; e_dv = 0; e_le = 0; e_dout = '0;
    endtask

    task automatic model_edge();
        bit v, c, err, cerr;
        int was;
        v = m_vd; c = m_cd;
        err  = v && (dec_code_err || dec_disp_err);
        cerr = v && dec_code_err;
        was  = m_mode;
        e_dv = (was == LOCKED) && v;
        e_le = (was == LOCKED) && err;
        if (was == LOCKED) e_dout = dec_data;
        case (was)
            HUNT: if (v) begin
                if (c && !dec_code_err) begin
                    m_mode = CONFIRM; m_commas = 1; m_srch = 0;
                end else begin
                    m_srch++;
                    if (m_srch == SEARCH_LEN) begin m_mode = SLIPPING; m_srch = 0; end
                end
            end
            SLIPPING: begin
                m_mode = SETTLE; m_wait = 0;
                m_slips = (m_slips >= 255) ? 255 : m_slips + 1;
            end
            SETTLE: begin
                m_wait++;
                if (m_wait == SLIP_WAIT) begin m_mode = HUNT; m_srch = 0; end
            end
            CONFIRM: begin
                if (cerr) begin m_mode = HUNT; m_srch = 0; end
                else if (v && c) begin
                    m_commas++;
                    if (m_commas == COMMA_CNT) begin m_mode = LOCKED; m_errs = 0; m_good = 0; end
                end
            end
            default: begin
                if (err) begin
                    m_errs++; m_good = 0;
                    if (m_errs >= ERR_LOSS) begin m_mode = HUNT; m_slips = 0; m_srch = 0; end
                end else if (v) begin
                    m_good++;
                    if (m_good >= GOOD_RUN) begin
                        if (m_errs > 0) begin m_errs--; m_good = 0; end
                        else m_good = GOOD_RUN;
                    end
                end
            end
        endcase
        m_vd = rx_valid;
        m_cd = is_comma(rx_data_in);
        e_sync = (m_mode == LOCKED);
        e_bs   = (m_mode == SLIPPING);
        e_drn  = (m_mode != SLIPPING);
    endtask

    task automatic compare();
        chk("sync", int'(sync), int'(e_sync));
        chk("bitslip", int'(bitslip), int'(e_bs));
        chk("dec_rst_n", int'(dec_rst_n), int'(e_drn));
        chk("data_valid", int'(data_valid), int'(e_dv));
        chk("link_err", int'(link_err), int'(e_le));
        chk("slip_cnt", int'(slip_cnt), m_slips);
        if (e_dv) chk("data_out", int'(data_out), int'(e_dout));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) begin
            n_edge++;
            model_edge();
        end
        compare();
        if (link_err === 1'b1) le_count++;
        if (bitslip === 1'b1) begin
            slip_edges.push_back(n_edge);
            misalign = (misalign == 0) ? 9 : misalign - 1;
        end
    endtask

    task automatic drive(input logic [9:0] w, input bit v, input logic [8:0] d, input bit ce, input bit de);
        rx_data_in   = w;
        rx_valid     = v;
        dec_data     = p_data;
        dec_code_err = p_code;
        dec_disp_err = p_disp;
        p_data = d; p_code = ce; p_disp = de;
    endtask

    task automatic drive_k();
        drive(K285N, 1'b1, 9'h1BC, 1'b0, 1'b0);
    endtask

    task automatic drive_d(input bit ce, input bit de);
        drive(noncomma(), 1'b1, {1'b0, 8'($urandom)}, ce, de);
    endtask

    task automatic rand_drive(input int pv, input int pc, input int pcode, input int pdisp);
        bit v, ce, de;
        v  = ($urandom_range(99) < pv);
        ce = ($urandom_range(99) < pcode);
        de = ($urandom_range(99) < pdisp);
        if (misalign == 0 && $urandom_range(99) < pc)
            drive($urandom_range(1) ? K285N : K285P, v, 9'h1BC, ce, de);
        else
            drive(noncomma(), v, {1'b0, 8'($urandom)}, ce, de);
    endtask

    task automatic assert_rst();
        rst = 1'b0;
        #1;
        model_reset();
        p_data = '0; p_code = 0; p_disp = 0;
        compare();
    endtask

    task automatic release_rst();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_edge = 0;
        slip_edges.delete();
    endtask

    function automatic int q_at(input int idx);
        return (slip_edges.size() > idx) ? slip_edges[idx] : -1;
    endfunction

    initial begin
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_sync", int'(sync), 0);
        chk("rst_bitslip", int'(bitslip), 0);
        chk("rst_dec_rst_n", int'(dec_rst_n), 0);
        chk("rst_data_valid", int'(data_valid), 0);
        chk("rst_link_err", int'(link_err), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_slip_cnt", int'(slip_cnt), 0);
        release_rst();

        // Aligned K28.5 stream: third comma locks, a later K28.5 appears 2 clocks after entry
        misalign = 0;
        drive_k();      step();
        chk("t1_dec_rst_n_first_clk", int'(dec_rst_n), 1);
        drive_d(0, 0);  step();
        drive_k();      step();
        drive_d(0, 0);  step();
        drive_k();      step();
        chk("t1_sync_before_third", int'(sync), 0);
        drive_d(0, 0);  step();
        chk("t1_sync_on_third", int'(sync), 1);
        drive_k();      step();
        drive_d(0, 0);  step();
        chk("t1_data_out_k285", int'(data_out), 'h1BC);
        chk("t1_data_valid", int'(data_valid), 1);

        // Misaligned by 3 bits: three slips 81 clocks apart, then lock
        assert_rst();
        release_rst();
        misalign = 3;
        for (int i = 0; i < 1000; i++) begin
            rand_drive(100, 25, 0, 0);
            step();
            if (sync === 1'b1) break;
        end
        chk("t2_sync", int'(sync), 1);
        chk("t2_slip_cnt", int'(slip_cnt), 3);
        chk("t2_slip0_edge", q_at(0), 65);
        chk("t2_slip1_edge", q_at(1), 146);
        chk("t2_slip2_edge", q_at(2), 227);

        // Error every 5th word: error count oscillates, sync holds
        le_count = 0;
        for (int i = 0; i < 40; i++) begin
            drive_d(i % 5 == 4, 0);
            step();
        end
        for (int i = 0; i < 8; i++) begin drive_d(0, 0); step(); end
        chk("t4_sync_held", int'(sync), 1);
        chk("t4_link_err_pulses", le_count, 8);

        // Four consecutive code errors drop sync and clear slip_cnt
        le_count = 0;
        for (int i = 0; i < 4; i++) begin drive_d(1, 0); step(); end
        for (int i = 0; i < 4; i++) begin drive_d(0, 0); step(); end
        chk("t3_link_err_pulses", le_count, 4);
        chk("t3_sync_dropped", int'(sync), 0);
        chk("t3_slip_cnt_cleared", int'(slip_cnt), 0);

        // COMMA_DET: disp_err tolerated, code_err restarts the comma count
        drive_k();     step();
        drive_k();     step();
        drive_d(0, 1); step();
        drive_d(1, 0); step();
        drive_k();     step();
        drive_k();     step();
        drive_d(0, 0); step();
        drive_d(0, 0); step();
        chk("t5_sync_after_restart", int'(sync), 0);
        drive_k();     step();
        drive_d(0, 0); step();
        chk("t5_sync_third_comma", int'(sync), 1);

        // Reset asserted during WAIT, then during SLIP
        assert_rst();
        release_rst();
        misalign = 5;
        for (int i = 0; i < 70; i++) begin rand_drive(100, 0, 0, 0); step(); end
        chk("t6_first_slip_edge", q_at(0), 65);
        #1 rst = 1'b0;
        #1;
        chk("t6_wait_rst_bitslip", int'(bitslip), 0);
        chk("t6_wait_rst_dec_rst_n", int'(dec_rst_n), 0);
        chk("t6_wait_rst_sync", int'(sync), 0);
        chk("t6_wait_rst_slip_cnt", int'(slip_cnt), 0);
        model_reset();
        p_data = '0; p_code = 0; p_disp = 0;
        release_rst();
        rand_drive(100, 0, 0, 0); step();
        chk("t6_dec_rst_n_after_release", int'(dec_rst_n), 1);
        for (int i = 1; i < 65; i++) begin rand_drive(100, 0, 0, 0); step(); end
        chk("t6_slip_at_65", int'(bitslip), 1);
        assert_rst();
        chk("t6_slip_rst_bitslip", int'(bitslip), 0);
        chk("t6_slip_rst_dec_rst_n", int'(dec_rst_n), 0);
        release_rst();

        // Dead link: slip counter saturates at 255
        for (int i = 0; i < 21000; i++) begin rand_drive(100, 0, 0, 0); step(); end
        chk("sat_slip_cnt", int'(slip_cnt), 255);

        // Random traffic with gaps, commas, errors and a rotating word boundary
        assert_rst();
        release_rst();
        misalign = 0;
        for (int i = 0; i < 4000; i++) begin rand_drive(80, 30, 3, 3); step(); end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
